// File: rtl/fpu_add_sub_pipe.sv
// fpu_add_sub_pipe: 3-stage pipelined floating-point adder/subtractor.
// S1 sorts by magnitude and aligns, S2 adds/subtracts with guard/round/sticky,
// S3 normalises, rounds to nearest-even and encodes.
// Optional feature macro: FPU_SPECIAL_EN (NaN/infinity handling and NV flag).
module fpu_add_sub_pipe #(
  parameter int unsigned EXPW  = 5,
  parameter int unsigned FRACW = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [EXPW+FRACW:0]   a,
  input  logic [EXPW+FRACW:0]   b,
  input  logic                  sub,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [EXPW+FRACW:0]   result,
  output logic [3:0]            flags
);
  localparam int unsigned W  = 1 + EXPW + FRACW;
  localparam int unsigned SW = FRACW + 4;   // hidden + fraction + guard/round/sticky
  localparam int unsigned CW = SW + 1;      // plus carry
  localparam int unsigned XW = EXPW + 1;    // exponent with overflow headroom
  localparam logic [XW-1:0] EMAX = XW'((2 ** EXPW) - 1);

  logic              r1_v, r2_v, r_out_v;
  logic              r1_sign, r1_sub, r2_sign, r2_sub;
  logic [EXPW-1:0]   r1_exp, r2_exp;
  logic [SW-1:0]     r1_mbig, r1_msml;
  logic [CW-1:0]     r2_sum;
  logic [W-1:0]      r_result;
  logic [3:0]        r_flags;

  // Whole pipeline advances unless a finished result is waiting downstream.
  logic w_adv;
  assign w_adv    = !r_out_v || outReady;
  assign inReady  = w_adv;
  assign outValid = r_out_v;
  assign result   = r_result;
  assign flags    = r_flags;

  // ---------------- S1: sort and align ----------------
  logic            w_sa, w_sb, w_effsub, w_swap, w_sign;
  logic [W-1:0]    w_big, w_sml;
  logic [EXPW-1:0] w_ebig, w_esml, w_diff;
  logic [SW-1:0]   w_mbig, w_msml, w_al;
  logic [2*SW-1:0] w_wide;

  assign w_sa     = a[W-1];
  assign w_sb     = b[W-1] ^ sub;
  assign w_effsub = w_sa ^ w_sb;
  assign w_swap   = b[W-2:0] > a[W-2:0];
  assign w_big    = w_swap ? b : a;
  assign w_sml    = w_swap ? a : b;
  assign w_sign   = w_swap ? w_sb : w_sa;
  assign w_ebig   = (w_big[W-2:FRACW] == '0) ? EXPW'(1) : w_big[W-2:FRACW];
  assign w_esml   = (w_sml[W-2:FRACW] == '0) ? EXPW'(1) : w_sml[W-2:FRACW];
  assign w_diff   = w_ebig - w_esml;
  assign w_mbig   = {w_big[W-2:FRACW] != '0, w_big[FRACW-1:0], 3'b000};
  assign w_msml   = {w_sml[W-2:FRACW] != '0, w_sml[FRACW-1:0], 3'b000};

  // Shift the smaller significand right, folding lost bits into sticky.
  always_comb begin
    w_wide = {w_msml, SW'(0)} >> w_diff;
    if (32'(w_diff) >= 32'(SW - 1))
      w_al = {(SW-1)'(0), |w_msml};
    else
      w_al = w_wide[2*SW-1:SW] | {(SW-1)'(0), |w_wide[SW-1:0]};
  end

`ifdef FPU_SPECIAL_EN
  localparam logic [W-1:0] QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, (FRACW-1)'(0)};
  logic w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_snan, w_spec, w_spec_nv;
  logic [W-1:0] w_spec_val;
  logic r1_spec, r1_spec_nv, r2_spec, r2_spec_nv;
  logic [W-1:0] r1_spec_val, r2_spec_val;

  assign w_nan_a = (a[W-2:FRACW] == '1) && (a[FRACW-1:0] != '0);
  assign w_nan_b = (b[W-2:FRACW] == '1) && (b[FRACW-1:0] != '0);
  assign w_inf_a = (a[W-2:FRACW] == '1) && (a[FRACW-1:0] == '0);
  assign w_inf_b = (b[W-2:FRACW] == '1) && (b[FRACW-1:0] == '0);
  assign w_snan  = (w_nan_a && !a[FRACW-1]) || (w_nan_b && !b[FRACW-1]);
  assign w_spec  = w_nan_a || w_nan_b || w_inf_a || w_inf_b;

  // Special-value result chosen up front and carried alongside the datapath.
  always_comb begin
    w_spec_val = QNAN;
    w_spec_nv  = 1'b0;
    if (w_nan_a || w_nan_b) begin
      w_spec_nv = w_snan;
    end else if (w_inf_a && w_inf_b && w_effsub) begin
      w_spec_nv = 1'b1;
    end else if (w_inf_a) begin
      w_spec_val = {w_sa, {EXPW{1'b1}}, FRACW'(0)};
    end else begin
      w_spec_val = {w_sb, {EXPW{1'b1}}, FRACW'(0)};
    end
  end
`endif

  // ---------------- S2: effective add/subtract ----------------
  logic [CW-1:0] w_sum;
  assign w_sum = r1_sub ? ({1'b0, r1_mbig} - {1'b0, r1_msml})
                        : ({1'b0, r1_mbig} + {1'b0, r1_msml});

  // ---------------- S3: normalise, round, encode ----------------
  logic [31:0]     w_lz, w_emin, w_sh;
  logic [SW-1:0]   w_n;
  logic [XW-1:0]   w_e, w_ef, w_efin;
  logic [FRACW+1:0] w_m;
  logic            w_rup, w_nx, w_of, w_zero, w_rsign;
  logic [FRACW-1:0] w_frac;
  logic [W-1:0]    w_res;
  logic [3:0]      w_flg;

  // Leading-zero count, subnormal-limited left shift, RNE rounding and packing.
  always_comb begin
    w_lz = 32'(SW);
    for (int unsigned i = 0; i < SW; i++)
      if (r2_sum[i]) w_lz = 32'(SW - 1 - i);
    w_emin = 32'(r2_exp) - 32'd1;
    w_sh   = (w_lz < w_emin) ? w_lz : w_emin;
    if (r2_sum[CW-1]) begin
      w_n = {r2_sum[CW-1:2], r2_sum[1] | r2_sum[0]};
      w_e = XW'(r2_exp) + XW'(1);
    end else begin
      w_n = r2_sum[SW-1:0] << w_sh;
      w_e = XW'(r2_exp) - XW'(w_sh);
    end
    w_ef    = w_n[SW-1] ? w_e : XW'(0);
    w_rup   = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m     = {1'b0, w_n[SW-1:3]} + (FRACW+2)'(w_rup);
    w_efin  = (w_ef == '0) ? XW'(w_m[FRACW]) : (w_ef + XW'(w_m[FRACW+1]));
    w_frac  = w_m[FRACW+1] ? FRACW'(0) : w_m[FRACW-1:0];
    w_of    = w_efin >= EMAX;
    w_nx    = (|w_n[2:0]) | w_of;
    w_zero  = (r2_sum == '0);
    w_rsign = (w_zero && r2_sub) ? 1'b0 : r2_sign;
    if (w_of)
      w_res = {w_rsign, {EXPW{1'b1}}, FRACW'(0)};
    else
      w_res = {w_rsign, w_efin[EXPW-1:0], w_frac};
    w_flg = {1'b0, w_of, (w_efin == '0) && w_nx, w_nx};
`ifdef FPU_SPECIAL_EN
    if (r2_spec) begin
      w_res = r2_spec_val;
      w_flg = {r2_spec_nv, 3'b000};
    end
`endif
  end

  // Stage valid bits and the output register; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v     <= 1'b0;
      r2_v     <= 1'b0;
      r_out_v  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_adv) begin
      r1_v     <= inValid;
      r2_v     <= r1_v;
      r_out_v  <= r2_v;
      r_result <= w_res;
      r_flags  <= w_flg;
    end
  end

  // Datapath stage registers; qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_sign <= w_sign;
      r1_sub  <= w_effsub;
      r1_exp  <= w_ebig;
      r1_mbig <= w_mbig;
      r1_msml <= w_al;
      r2_sign <= r1_sign;
      r2_sub  <= r1_sub;
      r2_exp  <= r1_exp;
      r2_sum  <= w_sum;
`ifdef FPU_SPECIAL_EN
      r1_spec     <= w_spec;
      r1_spec_nv  <= w_spec_nv;
      r1_spec_val <= w_spec_val;
      r2_spec     <= r1_spec;
      r2_spec_nv  <= r1_spec_nv;
      r2_spec_val <= r1_spec_val;
`endif
    end
  end
endmodule
